// File: rtl/vx_csr_timeit_unit.sv
// Multi-channel commit-window timer. Each channel watches committed PCs against a [start,end)
// range and records first-hit/last-hit cycle stamps plus a saturating hit count, all CSR-mapped.
module vx_csr_timeit_unit #(
    parameter int                       NUM_CHANNELS  = 4,
    parameter int                       NUM_LANES     = 1,
    parameter int                       CTR_WIDTH     = 64,
    parameter int                       CSR_ADDR_BITS = 12,
    parameter logic [CSR_ADDR_BITS-1:0] CSR_BASE      = 12'hB20
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      busy,
    input  logic [NUM_LANES-1:0]      commit_valid,
    input  logic [NUM_LANES*32-1:0]   commit_pc,
    input  logic                      write_enable,
    input  logic [CSR_ADDR_BITS-1:0]  write_addr,
    input  logic [31:0]               write_data,
    input  logic [CSR_ADDR_BITS-1:0]  read_addr,
    output logic [31:0]               read_data,
    output logic                      read_hit,
    output logic [NUM_CHANNELS-1:0]   timeit_running
);

    localparam int WIN_SIZE = 8 * NUM_CHANNELS;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_RUNNING = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    typedef struct packed {
        logic [31:0]          range_lo;
        logic [31:0]          range_hi;
        logic                 enable;
        logic                 oneshot;
        state_e               state;
        logic [CTR_WIDTH-1:0] t_start;
        logic [CTR_WIDTH-1:0] t_end;
        logic [23:0]          hits;
    } chan_t;

    logic [CTR_WIDTH-1:0]     cyc_q, cyc_d;
    chan_t                    chan_q [NUM_CHANNELS];
    chan_t                    chan_d [NUM_CHANNELS];

    logic [NUM_CHANNELS-1:0]  hit;
    logic                     any_valid;
    logic [CSR_ADDR_BITS-1:0] wr_rel, rd_rel;
    logic                     wr_in_win;
    logic [2:0]               wr_off, rd_off;
    int                       wr_ch_idx, rd_ch_idx;

    // Range match per channel; an empty or inverted range (lo >= hi) can never match.
    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        hit       = '0;
        any_valid = 1'b0;
        for (int l = 0; l < NUM_LANES; l++) begin
            any_valid = any_valid | commit_valid[l];
            for (int c = 0; c < NUM_CHANNELS; c++) begin
                if (commit_valid[l] &&
                    commit_pc[l*32 +: 32] >= chan_q[c].range_lo &&
                    commit_pc[l*32 +: 32] <  chan_q[c].range_hi) begin
                    hit[c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        cyc_d     = busy ? cyc_q + CTR_WIDTH'(1) : cyc_q;
        wr_rel    = write_addr - CSR_BASE;
        wr_in_win = write_enable && (write_addr >= CSR_BASE) && (int'(wr_rel) < WIN_SIZE);
        wr_off    = wr_rel[2:0];
        wr_ch_idx = int'(wr_rel[CSR_ADDR_BITS-1:3]);

        for (int c = 0; c < NUM_CHANNELS; c++) begin
            chan_d[c] = chan_q[c];
            // A write to a channel's writable registers overrides a same-cycle hit.
            if (wr_in_win && wr_ch_idx == c && wr_off <= 3'd2) begin
                case (wr_off)
                    3'd0: begin
                        chan_d[c].range_lo = write_data;
                        chan_d[c].enable   = 1'b0;
                        chan_d[c].state    = ST_IDLE;
                    end
                    3'd1: begin
                        chan_d[c].range_hi = write_data;
                        chan_d[c].enable   = 1'b1;
                        chan_d[c].state    = ST_ARMED;
                        chan_d[c].t_start  = '0;
                        chan_d[c].t_end    = '0;
                        chan_d[c].hits     = '0;
                    end
                    default: begin
                        chan_d[c].enable  = write_data[0];
                        chan_d[c].oneshot = write_data[2];
                        if (write_data[1]) begin
                            chan_d[c].t_start = '0;
                            chan_d[c].t_end   = '0;
                            chan_d[c].hits    = '0;
                            chan_d[c].state   = write_data[0] ? ST_ARMED : ST_IDLE;
                        end else if (!write_data[0]) begin
                            chan_d[c].state = ST_IDLE;
                        end else if (chan_q[c].state == ST_IDLE) begin
                            chan_d[c].state = ST_ARMED;
                        end
                    end
                endcase
            end else begin
                case (chan_q[c].state)
                    ST_ARMED: begin
                        if (hit[c]) begin
                            chan_d[c].state   = ST_RUNNING;
                            chan_d[c].t_start = cyc_q;
                            chan_d[c].t_end   = cyc_q;
                            chan_d[c].hits    = 24'd1;
                        end
                    end
                    ST_RUNNING: begin
                        if (hit[c]) begin
                            chan_d[c].t_end = cyc_q;
                            if (chan_q[c].hits != '1) chan_d[c].hits = chan_q[c].hits + 24'd1;
                        end else if (chan_q[c].oneshot && any_valid) begin
                            chan_d[c].state = ST_DONE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cyc_q <= '0;
            // NOTE: the channel array is plain flops (not a RAM), so every entry is reset explicitly.
            for (int c = 0; c < NUM_CHANNELS; c++) chan_q[c] <= '0;
        end else begin
            // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
            cyc_q <= cyc_d;
            for (int c = 0; c < NUM_CHANNELS; c++) chan_q[c] <= chan_d[c];
        end
    end

    always_comb begin
        rd_rel    = read_addr - CSR_BASE;
        read_hit  = (read_addr >= CSR_BASE) && (int'(rd_rel) < WIN_SIZE);
        rd_off    = rd_rel[2:0];
        rd_ch_idx = int'(rd_rel[CSR_ADDR_BITS-1:3]);
        read_data = '0;
        for (int c = 0; c < NUM_CHANNELS; c++) begin
            timeit_running[c] = (chan_q[c].state == ST_RUNNING);
            if (read_hit && rd_ch_idx == c) begin
                case (rd_off)
                    3'd0: read_data = chan_q[c].range_lo;
                    3'd1: read_data = chan_q[c].range_hi;
                    3'd2: read_data = {29'd0, chan_q[c].oneshot, 1'b0, chan_q[c].enable};
                    3'd3: read_data = {chan_q[c].hits, 6'd0, chan_q[c].state};
                    3'd4: read_data = chan_q[c].t_start[31:0];
                    3'd5: read_data = 32'(chan_q[c].t_start >> 32);
                    3'd6: read_data = chan_q[c].t_end[31:0];
                    default: read_data = 32'(chan_q[c].t_end >> 32);
                endcase
            end
        end
    end

endmodule

// File: tb/tb_vx_csr_timeit_unit.sv
// Self-checking bench for vx_csr_timeit_unit: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a behavioural channel model.
module tb_vx_csr_timeit_unit;

    localparam int          NCH   = 4;
    localparam int          NL    = 2;
    localparam logic [11:0] BASE  = 12'hB20;
    localparam int          HMAX  = (1 << 24) - 1;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              busy;
    logic [NL-1:0]     commit_valid;
    logic [NL*32-1:0]  commit_pc;
    logic              write_enable;
    logic [11:0]       write_addr;
    logic [31:0]       write_data;
    logic [11:0]       read_addr;
    logic [31:0]       read_data;
    logic              read_hit;
    logic [NCH-1:0]    timeit_running;

    int n_checks = 0;
    int n_fail   = 0;

    vx_csr_timeit_unit #(
        .NUM_CHANNELS(NCH), .NUM_LANES(NL), .CTR_WIDTH(64), .CSR_ADDR_BITS(12), .CSR_BASE(BASE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .busy(busy),
        .commit_valid(commit_valid), .commit_pc(commit_pc),
        .write_enable(write_enable), .write_addr(write_addr), .write_data(write_data),
        .read_addr(read_addr), .read_data(read_data), .read_hit(read_hit),
        .timeit_running(timeit_running)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic [63:0] m_cyc;
    logic [31:0] m_lo [NCH];
    logic [31:0] m_hi [NCH];
    bit          m_en [NCH];
    bit          m_os [NCH];
    int          m_st [NCH];   // 0 idle, 1 armed, 2 running, 3 done
    logic [63:0] m_t0 [NCH];
    logic [63:0] m_t1 [NCH];
    int          m_hits [NCH];

    task automatic model_reset();
        m_cyc = 0;
        for (int c = 0; c < NCH; c++) begin
            m_lo[c] = 0; m_hi[c] = 0; m_en[c] = 0; m_os[c] = 0;
            m_st[c] = 0; m_t0[c] = 0; m_t1[c] = 0; m_hits[c] = 0;
        end
    endtask

    function automatic bit in_win(logic [11:0] a);
        return (int'(a) >= int'(BASE)) && (int'(a) < int'(BASE) + 8 * NCH);
    endfunction

    // Applies one clock edge worth of the channel rules to the model state.
    task automatic model_step();
        bit any_v;
        int wch, woff;
        any_v = |commit_valid;
        wch   = (int'(write_addr) - int'(BASE)) / 8;
        woff  = (int'(write_addr) - int'(BASE)) % 8;
        for (int c = 0; c < NCH; c++) begin
            bit h = 0;
            for (int l = 0; l < NL; l++) begin
                logic [31:0] pc = commit_pc[l*32 +: 32];
                if (commit_valid[l] && pc >= m_lo[c] && pc < m_hi[c]) h = 1;
            end
            if (write_enable && in_win(write_addr) && wch == c && woff <= 2) begin
                if (woff == 0) begin
                    m_lo[c] = write_data; m_en[c] = 0; m_st[c] = 0;
                end else if (woff == 1) begin
                    m_hi[c] = write_data; m_en[c] = 1; m_st[c] = 1;
                    m_t0[c] = 0; m_t1[c] = 0; m_hits[c] = 0;
                end else begin
                    m_en[c] = write_data[0];
                    m_os[c] = write_data[2];
                    if (write_data[1]) begin
                        m_t0[c] = 0; m_t1[c] = 0; m_hits[c] = 0;
                        m_st[c] = m_en[c] ? 1 : 0;
                    end else if (!m_en[c]) m_st[c] = 0;
                    else if (m_st[c] == 0) m_st[c] = 1;
                end
            end else if (m_st[c] == 1 && h) begin
                m_st[c] = 2; m_t0[c] = m_cyc; m_t1[c] = m_cyc; m_hits[c] = 1;
            end else if (m_st[c] == 2) begin
                if (h) begin
                    m_t1[c] = m_cyc;
                    if (m_hits[c] < HMAX) m_hits[c]++;
                end else if (m_os[c] && any_v) m_st[c] = 3;
            end
        end
        if (busy) m_cyc = m_cyc + 64'd1;
    endtask

    function automatic logic [31:0] model_read(logic [11:0] a);
        int c, off;
        if (!in_win(a)) return 32'd0;
        c   = (int'(a) - int'(BASE)) / 8;
        off = (int'(a) - int'(BASE)) % 8;
        case (off)
            0: return m_lo[c];
            1: return m_hi[c];
            2: return {29'd0, m_os[c], 1'b0, m_en[c]};
            3: return (32'(m_hits[c]) << 8) | 32'(m_st[c]);
            4: return m_t0[c][31:0];
            5: return m_t0[c][63:32];
            6: return m_t1[c][31:0];
            default: return m_t1[c][63:32];
        endcase
    endfunction

    function automatic logic [NCH-1:0] model_running();
        logic [NCH-1:0] r = '0;
        for (int c = 0; c < NCH; c++) r[c] = (m_st[c] == 2);
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Compare process: outputs against the model, every cycle, well after the edge.
    always @(posedge clk) begin
        #4;
        check("running", 64'(timeit_running), 64'(model_running()));
        check("read_hit", 64'(read_hit), 64'(in_win(read_addr)));
        check("read_data", 64'(read_data), 64'(model_read(read_addr)));
    end

    // ---------------- driver helpers ----------------
    task automatic tick();
        @(posedge clk);
        if (reset_n) model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic wr(input int ch, input int off, input logic [31:0] d);
        write_enable = 1'b1;
        write_addr   = BASE + 12'(8 * ch + off);
        write_data   = d;
        tick();
        write_enable = 1'b0;
    endtask

    task automatic commit(input logic [31:0] pc0, input bit v0, input logic [31:0] pc1, input bit v1);
        commit_pc    = {pc1, pc0};
        commit_valid = {v1, v0};
        tick();
        commit_valid = '0;
    endtask

    task automatic wait_cyc(input logic [63:0] c);
        int n = 0;
        while (m_cyc != c && n < 500) begin
            tick();
            n++;
        end
        check("wait_cyc_reached", m_cyc, c);
    endtask

    task automatic rd(input string name, input int ch, input int off, input logic [31:0] exp);
        read_addr = BASE + 12'(8 * ch + off);
        #1;
        check(name, 64'(read_data), 64'(exp));
    endtask

    logic [63:0] rec_cyc;

    initial begin
        reset_n = 1'b0; busy = 1'b0; commit_valid = '0; commit_pc = '0;
        write_enable = 1'b0; write_addr = '0; write_data = '0; read_addr = BASE;
        model_reset();
        @(negedge clk);
        rd("reset_status0", 0, 3, 32'h0);
        check("reset_running", 64'(timeit_running), 64'h0);

        // 1: basic window on ch0
        busy = 1'b1;
        do_reset();
        wr(0, 0, 32'h100);
        wr(0, 1, 32'h140);
        wait_cyc(64'd10); commit(32'h100, 1, 32'h0, 0);
        wait_cyc(64'd25); commit(32'h13C, 1, 32'h0, 0);
        rd("t1_start_l", 0, 4, 32'd10);
        rd("t1_start_h", 0, 5, 32'd0);
        rd("t1_end_l",   0, 6, 32'd25);
        rd("t1_status",  0, 3, 32'h202);
        check("t1_running", 64'(timeit_running), 64'h1);

        // 2: oneshot on ch1
        busy = 1'b0;
        do_reset();
        wr(1, 0, 32'h200);
        wr(1, 1, 32'h210);
        wr(1, 2, 32'h5);
        rd("t2_ctrl", 1, 2, 32'h5);
        busy = 1'b1;
        wait_cyc(64'd5); commit(32'h200, 1, 32'h0, 0);
        wait_cyc(64'd6); commit(32'h204, 1, 32'h0, 0);
        wait_cyc(64'd7); commit(32'h300, 1, 32'h0, 0);
        wait_cyc(64'd9); commit(32'h208, 1, 32'h0, 0);
        rd("t2_status", 1, 3, 32'h203);
        rd("t2_start_l", 1, 4, 32'd5);
        rd("t2_end_l", 1, 6, 32'd6);

        // 3: two lanes
        do_reset();
        wr(0, 0, 32'h100); wr(0, 1, 32'h140);
        wr(2, 0, 32'h400); wr(2, 1, 32'h500);
        commit(32'h100, 1, 32'h104, 1);
        rd("t3_ch0_one", 0, 3, 32'h102);
        commit(32'h108, 1, 32'h400, 1);
        rd("t3_ch0_two", 0, 3, 32'h202);
        rd("t3_ch2", 2, 3, 32'h102);

        // 4: RANGE_H write collides with a hit
        commit_pc = {32'h0, 32'h110}; commit_valid = 2'b01;
        wr(0, 1, 32'h140);
        commit_valid = '0;
        rd("t4_status_armed", 0, 3, 32'h001);
        rd("t4_start_zero", 0, 4, 32'h0);
        rec_cyc = m_cyc;
        commit(32'h110, 1, 32'h0, 0);
        rd("t4_status_run", 0, 3, 32'h102);
        rd("t4_start_cyc", 0, 4, rec_cyc[31:0]);

        // 5: 32-bit rollover of the stamps; empty range never hits
        do_reset();
        wr(0, 0, 32'h100); wr(0, 1, 32'h140);
        wr(3, 0, 32'h600); wr(3, 1, 32'h600);
        force dut.cyc_q = 64'hFFFF_FFFE;
        #1;
        release dut.cyc_q;
        m_cyc = 64'hFFFF_FFFE;
        tick();
        commit(32'h100, 1, 32'h0, 0);
        commit(32'h104, 1, 32'h600, 1);
        rd("t5_start_l", 0, 4, 32'hFFFF_FFFF);
        rd("t5_start_h", 0, 5, 32'h0);
        rd("t5_end_l", 0, 6, 32'h0);
        rd("t5_end_h", 0, 7, 32'h1);
        rd("t5_empty_range", 3, 3, 32'h001);

        // 6: async reset mid-RUNNING
        #2;
        reset_n = 1'b0;
        model_reset();
        read_addr = BASE + 12'd3;
        #1;
        check("t6_status_in_reset", 64'(read_data), 64'h0);
        @(negedge clk);
        reset_n = 1'b1;
        rd("t6_status", 0, 3, 32'h0);
        rd("t6_start_l", 0, 4, 32'h0);
        rd("t6_end_h", 0, 7, 32'h0);
        read_addr = BASE + 12'(8 * NCH);
        #1;
        check("t6_oow_hit", 64'(read_hit), 64'h0);
        check("t6_oow_data", 64'(read_data), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            int r;
            busy         = ($urandom_range(0, 3) != 0);
            commit_valid = NL'($urandom);
            commit_pc    = {32'h100 + 32'($urandom_range(0, 320)) * 4,
                            32'h100 + 32'($urandom_range(0, 320)) * 4};
            write_enable = ($urandom_range(0, 5) == 0);
            r = $urandom_range(0, 8 * NCH + 1);
            write_addr   = (r == 8 * NCH + 1) ? BASE - 12'd1 : BASE + 12'(r);
            write_data   = $urandom_range(0, 1) ? 32'h100 + 32'($urandom_range(0, 320)) * 4
                                                : 32'($urandom_range(0, 7));
            read_addr    = BASE - 12'd2 + 12'($urandom_range(0, 8 * NCH + 3));
            tick();
        end
        write_enable = 1'b0;
        commit_valid = '0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
